// File: rtl/mem_access_ctrl_if.sv
// Pipeline-side request/response bus of the memory-stage load/store controller.
// master = pipeline, slave = controller.
interface mem_access_ctrl_if;
   logic        req_valid;
   logic        req_ready;
   logic        req_write;
   logic [1:0]  req_size;
   logic        req_signed;
   logic [31:0] req_addr;
   logic [31:0] req_wdata;
   logic        resp_valid;
   logic [31:0] resp_rdata;
   logic        resp_error;

   modport master (
      output req_valid, req_write, req_size, req_signed, req_addr, req_wdata,
      input  req_ready, resp_valid, resp_rdata, resp_error
   );

   modport slave (
      input  req_valid, req_write, req_size, req_signed, req_addr, req_wdata,
      output req_ready, resp_valid, resp_rdata, resp_error
   );
endinterface

// File: rtl/mem_access_ctrl.sv
// Load/store initiator for a byte-addressed, big-endian data RAM: pulses Enable
// around stable address/data and sign/zero-extends load results.
//
// state  | meaning
// IDLE   | ready for a request; mem_* outputs at 0
// SETUP  | address/size/rw/data driven, enable still low
// ACCESS | enable high for ACCESS_CYCLES cycles (down-counter)
// RESP   | one-cycle response pulse; mem_* still held, enable low
module mem_access_ctrl #(
   parameter int unsigned ADDR_LIMIT    = 256,
   parameter int unsigned ACCESS_CYCLES = 1
) (
   input  logic        clk,
   input  logic        reset,
   mem_access_ctrl_if.slave bus,
   output logic        mem_enable,
   output logic        mem_rw,
   output logic [31:0] mem_addr,
   output logic [31:0] mem_wdata,
   output logic [1:0]  mem_size,
   input  logic [31:0] mem_rdata
);

   typedef enum logic [1:0] {IDLE, SETUP, ACCESS, RESP} state_t;

   localparam logic [32:0] LIMIT    = 33'(ADDR_LIMIT);
   localparam logic [3:0]  CNT_LOAD = 4'(ACCESS_CYCLES - 1);

   state_t      state;
   logic [3:0]  cnt;
   logic        ld_signed;
   logic        resp_valid;
   logic        resp_error;
   logic [31:0] resp_rdata;

   logic [32:0] nbytes;
   logic [32:0] end_addr;
   logic        req_err;
   logic [31:0] wdata_mask;
   logic [31:0] rdata_ext;

   // end address is formed in 33 bits so a request near 2^32 cannot wrap into range
   always_comb begin
      nbytes     = 33'd4;
      wdata_mask = bus.req_wdata;
      case (bus.req_size)
         2'b00: begin
            nbytes     = 33'd1;
            wdata_mask = {24'b0, bus.req_wdata[7:0]};
         end
         2'b01: begin
            nbytes     = 33'd2;
            wdata_mask = {16'b0, bus.req_wdata[15:0]};
         end
         default: ;
      endcase
      end_addr = {1'b0, bus.req_addr} + nbytes;
      req_err  = (bus.req_size == 2'b11)
              || (bus.req_size == 2'b01 && bus.req_addr[0])
              || (bus.req_size == 2'b10 && bus.req_addr[1:0] != 2'b00)
              || (end_addr > LIMIT);
   end

   always_comb begin
      rdata_ext = mem_rdata;
      case (mem_size)
         2'b00:   rdata_ext = {{24{ld_signed & mem_rdata[7]}}, mem_rdata[7:0]};
         2'b01:   rdata_ext = {{16{ld_signed & mem_rdata[15]}}, mem_rdata[15:0]};
         default: ;
      endcase
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         state      <= IDLE;
         cnt        <= 4'd0;
         ld_signed  <= 1'b0;
         resp_valid <= 1'b0;
         resp_error <= 1'b0;
         resp_rdata <= 32'd0;
         mem_enable <= 1'b0;
         mem_rw     <= 1'b0;
         mem_addr   <= 32'd0;
         mem_wdata  <= 32'd0;
         mem_size   <= 2'b00;
      end else begin
         case (state)
            IDLE: begin
               if (bus.req_valid) begin
                  if (req_err) begin
                     state      <= RESP;
                     resp_valid <= 1'b1;
                     resp_error <= 1'b1;
                     resp_rdata <= 32'd0;
                  end else begin
                     state     <= SETUP;
                     ld_signed <= bus.req_signed;
                     mem_rw    <= bus.req_write;
                     mem_addr  <= bus.req_addr;
                     mem_size  <= bus.req_size;
                     mem_wdata <= wdata_mask;
                  end
               end
            end
            SETUP: begin
               state      <= ACCESS;
               mem_enable <= 1'b1;
               cnt        <= CNT_LOAD;
            end
            ACCESS: begin
               if (cnt == 4'd0) begin
                  state      <= RESP;
                  mem_enable <= 1'b0;
                  resp_valid <= 1'b1;
                  resp_error <= 1'b0;
                  resp_rdata <= mem_rw ? 32'd0 : rdata_ext;
               end else begin
                  cnt <= cnt - 4'd1;
               end
            end
            RESP: begin
               state      <= IDLE;
               resp_valid <= 1'b0;
               resp_error <= 1'b0;
               resp_rdata <= 32'd0;
               mem_rw     <= 1'b0;
               mem_addr   <= 32'd0;
               mem_wdata  <= 32'd0;
               mem_size   <= 2'b00;
            end
            default: state <= IDLE;
         endcase
      end
   end

   assign bus.req_ready  = (state == IDLE);
   assign bus.resp_valid = resp_valid;
   assign bus.resp_error = resp_error;
   assign bus.resp_rdata = resp_rdata;

endmodule
